// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one counter instance between NUM_REQ requesters.
// Optional macro COUNTER_ARB_ZERO_SKIP_EN: a zero target completes without starting the counter.
module counter_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 7,
    parameter int OWN_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]  req_cnt_val_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            req_done_o,
    output logic                          cnt_start_o,
    output logic [CNT_WIDTH-1:0]          cnt_val_o,
    input  logic                          cnt_idle_i,
    input  logic                          cnt_done_i,
    output logic                          busy_o,
    output logic [OWN_W-1:0]              owner_o
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [OWN_W-1:0]     rr_ptr;
    logic [OWN_W-1:0]     owner;
    logic [OWN_W-1:0]     winner;
    logic [CNT_WIDTH-1:0] val;
    logic [CNT_WIDTH-1:0] winner_val;

    // First set request at or above rr_ptr, wrapping around.
    always_comb begin : pick_winner
        int  idx;
        logic found;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        idx    = 0;
        found  = 1'b0;
        winner = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                winner = OWN_W'(idx);
                found  = 1'b1;
            end
        end
        winner_val = req_cnt_val_i[int'(winner)*CNT_WIDTH +: CNT_WIDTH];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            val    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt != IDLE) begin
                owner <= winner;
                val   <= winner_val;
            end
            if (state == RELEASE)
                rr_ptr <= (owner == OWN_W'(NUM_REQ-1)) ? '0 : owner + OWN_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|req_i && cnt_idle_i) begin
`ifdef COUNTER_ARB_ZERO_SKIP_EN
                    state_nxt = (winner_val == '0) ? RELEASE : START;
`else
                    state_nxt = START;
`endif
                end
            end
            START:   state_nxt = WAIT;
            WAIT:    if (cnt_done_i) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        gnt_o       = '0;
        req_done_o  = '0;
        cnt_start_o = 1'b0;
        busy_o      = (state != IDLE);
        if (state != IDLE)
            gnt_o[owner] = 1'b1;
        if (state == START)
            cnt_start_o = 1'b1;
        if (state == RELEASE)
            req_done_o[owner] = 1'b1;
    end

    assign cnt_val_o = val;
    assign owner_o   = owner;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural counter model.
// Expectations follow COUNTER_ARB_ZERO_SKIP_EN when the same define is applied.
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] req_cnt_val_i;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   req_done_o;
    logic           cnt_start_o;
    logic [W-1:0]   cnt_val_o;
    logic           cnt_idle_i;
    logic           cnt_done_i;
    logic           busy_o;
    logic [1:0]     owner_o;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int multi_hot = 0;

    logic hold_busy;
    int   done_delay;
    logic m_busy;
    logic m_done;
    int   m_left;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] vals;
        int             own;
        logic [W-1:0]   val;
    } vec_t;

    vec_t tbl [8];

    counter_arbiter #(.NUM_REQ(N), .CNT_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .req_cnt_val_i (req_cnt_val_i),
        .gnt_o         (gnt_o),
        .req_done_o    (req_done_o),
        .cnt_start_o   (cnt_start_o),
        .cnt_val_o     (cnt_val_o),
        .cnt_idle_i    (cnt_idle_i),
        .cnt_done_i    (cnt_done_i),
        .busy_o        (busy_o),
        .owner_o       (owner_o)
    );

    always #5 clk = ~clk;

    // Counter model: busy after a start, one-cycle done done_delay edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (cnt_start_o) begin
                m_busy <= 1'b1;
                m_left <= done_delay;
            end else if (m_busy) begin
                if (m_left <= 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    assign cnt_idle_i = !m_busy && !hold_busy;
    assign cnt_done_i = m_done;

    always @(negedge clk) begin
        if ($countones(gnt_o) > 1) multi_hot++;
        if (cnt_start_o) start_cnt++;
        if (req_done_o != '0) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One full run: grant, start, counter done, done pulse, release to IDLE.
    task automatic run_txn(input vec_t v, input string tag);
        int s0;
        int d0;
        bit ok;
        logic [N-1:0] oh;
        oh = 4'b0001 << v.own;
        req_i = v.req;
        req_cnt_val_i = v.vals;
        s0 = start_cnt;
        d0 = done_cnt;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cnt_start_o) begin ok = 1'b1; break; end
        end
        check({tag, " start_seen"}, 32'(ok), 1);
        if (!ok) return;
        check({tag, " gnt"}, 32'(gnt_o), 32'(oh));
        check({tag, " cnt_val"}, 32'(cnt_val_o), 32'(v.val));
        check({tag, " owner"}, 32'(owner_o), 32'(v.own));
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cnt_done_i) begin ok = 1'b1; break; end
            if (req_done_o != '0) break;
        end
        check({tag, " cnt_done_seen"}, 32'(ok), 1);
        if (!ok) return;
        @(negedge clk);
        check({tag, " req_done"}, 32'(req_done_o), 32'(oh));
        check({tag, " gnt_release"}, 32'(gnt_o), 32'(oh));
        @(negedge clk);
        check({tag, " gnt_after"}, 32'(gnt_o), 0);
        check({tag, " busy_after"}, 32'(busy_o), 0);
        check({tag, " start_pulses"}, 32'(start_cnt - s0), 1);
        check({tag, " done_pulses"}, 32'(done_cnt - d0), 1);
    endtask

    initial begin
        int  s0;
        int  d0;
        bit  ok;

        tbl[0] = '{4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 0, 7'd1};
        tbl[1] = '{4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 1, 7'd2};
        tbl[2] = '{4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 2, 7'd3};
        tbl[3] = '{4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 3, 7'd4};
        tbl[4] = '{4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 0, 7'd1};
        tbl[5] = '{4'b0100, {7'd0, 7'd33, 7'd0, 7'd0}, 2, 7'd33};
        tbl[6] = '{4'b0101, {7'd0, 7'd20, 7'd0, 7'd10}, 0, 7'd10};
        tbl[7] = '{4'b0101, {7'd0, 7'd20, 7'd0, 7'd10}, 2, 7'd20};

        rst = 1'b1;
        req_i = '0;
        req_cnt_val_i = '0;
        hold_busy = 1'b0;
        done_delay = 3;
        #1;
        check("reset gnt", 32'(gnt_o), 0);
        check("reset req_done", 32'(req_done_o), 0);
        check("reset start", 32'(cnt_start_o), 0);
        check("reset cnt_val", 32'(cnt_val_o), 0);
        check("reset busy", 32'(busy_o), 0);
        check("reset owner", 32'(owner_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single requester with a slow counter.
        done_delay = 6;
        run_txn('{4'b0001, {7'd0, 7'd0, 7'd0, 7'd5}, 0, 7'd5}, "single");
        req_i = '0;
        check("single val_held", 32'(cnt_val_o), 5);
        done_delay = 3;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Rotation with all requests held, then fairness after the pointer moves.
        for (int i = 0; i < 8; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));
        req_i = '0;

        // Idle gating: no grant while the counter reports busy.
        hold_busy = 1'b1;
        req_i = 4'b0010;
        req_cnt_val_i = {7'd0, 7'd0, 7'd7, 7'd0};
        repeat (5) @(negedge clk);
        check("gate busy", 32'(busy_o), 0);
        check("gate gnt", 32'(gnt_o), 0);
        hold_busy = 1'b0;
        @(negedge clk);
        check("gate start", 32'(cnt_start_o), 1);
        check("gate gnt_on", 32'(gnt_o), 32'(4'b0010));
        check("gate cnt_val", 32'(cnt_val_o), 7);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_done_o != '0) begin ok = 1'b1; break; end
        end
        check("gate done", 32'(req_done_o), 32'(4'b0010));
        req_i = '0;
        @(negedge clk);

        // Reset in the middle of WAIT abandons the run.
        req_i = 4'b0001;
        req_cnt_val_i = {7'd0, 7'd0, 7'd0, 7'd9};
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cnt_start_o) begin ok = 1'b1; break; end
        end
        check("midrst start_seen", 32'(ok), 1);
        repeat (2) @(negedge clk);
        check("midrst busy_before", 32'(busy_o), 1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("midrst gnt", 32'(gnt_o), 0);
        check("midrst busy", 32'(busy_o), 0);
        check("midrst start", 32'(cnt_start_o), 0);
        check("midrst cnt_val", 32'(cnt_val_o), 0);
        check("midrst owner", 32'(owner_o), 0);
        req_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst no_done", 32'(done_cnt - d0), 0);
        run_txn('{4'b0110, {7'd0, 7'd6, 7'd5, 7'd0}, 1, 7'd5}, "postrst");
        req_i = '0;
        @(negedge clk);

        // Zero target value.
        s0 = start_cnt;
        req_cnt_val_i = '0;
`ifdef COUNTER_ARB_ZERO_SKIP_EN
        req_i = 4'b0010;
        @(negedge clk);
        check("zero req_done", 32'(req_done_o), 32'(4'b0010));
        check("zero gnt", 32'(gnt_o), 32'(4'b0010));
        check("zero start", 32'(cnt_start_o), 0);
        req_i = '0;
        @(negedge clk);
        check("zero done_once", 32'(req_done_o), 0);
        check("zero busy_after", 32'(busy_o), 0);
        check("zero no_start", 32'(start_cnt - s0), 0);
`else
        run_txn('{4'b0010, {N*W{1'b0}}, 1, 7'd0}, "zero");
        req_i = '0;
`endif

        check("gnt_onehot", 32'(multi_hot), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
